// File: rtl/triangle_pkg.sv
// Shared types and defaults for the triangle classifier.
//   TRI_WIDTH    default side width
//   TRI_CNT_W    default triangle counter width
//   tri_flags_t  classification flags of one result
//   tri_sorted_t sorted side triple at the default width
package triangle_pkg;

    localparam int unsigned TRI_WIDTH = 8;
    localparam int unsigned TRI_CNT_W = 16;

    // "tri" is a reserved word, so the strict-triangle flag is is_tri.
    typedef struct packed {
        logic is_tri;
        logic degen;
        logic equ;
        logic iso;
        logic right;
    } tri_flags_t;

    typedef struct packed {
        logic [TRI_WIDTH-1:0] max;
        logic [TRI_WIDTH-1:0] mid;
        logic [TRI_WIDTH-1:0] min;
    } tri_sorted_t;

endpackage

// File: rtl/triangle_classifier_sort3.sv
// Combinational three-input sorter.
//   a, b, c        unsigned inputs
//   max, mid, min  the inputs in descending order (ties in any order)
module tri_sort3 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] mid,
    output logic [WIDTH-1:0] min
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    always_comb begin
        hi  = (a >= b) ? a : b;
        lo  = (a >= b) ? b : a;
        max = hi;
        mid = lo;
        min = c;
        if (c >= hi) begin
            max = c;
            mid = hi;
            min = lo;
        end else if (c >= lo) begin
            mid = c;
            min = lo;
        end
    end

endmodule

// File: rtl/triangle_classifier.sv
// Two-stage streaming triangle classifier with a saturating triangle counter.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake; in_ready is combinational from out_ready
//   a, b, c              side lengths
//   out_valid, out_ready output handshake
//   is_tri .. is_right   registered classification flags
//   cnt_clr, tri_cnt     synchronous clear, count of delivered strict triangles
// Build option: define TRIANGLE_RIGHT_EN to compute is_right; otherwise it reads 0.
module triangle_classifier
    import triangle_pkg::*;
#(
    parameter int unsigned WIDTH = TRI_WIDTH,
    parameter int unsigned CNT_W = TRI_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_tri,
    output logic             is_degen,
    output logic             is_equ,
    output logic             is_iso,
    output logic             is_right,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] tri_cnt
);

    logic             en;
    logic             accept;

    logic [WIDTH-1:0] srt_max, srt_mid, srt_min;

    // Stage 1
    logic [WIDTH-1:0] max_q, mid_q, min_q;
    logic             eq_ab_q, eq_bc_q, eq_ac_q, zero_q, v1_q;

    // Stage 2
    tri_flags_t       flags_d, flags_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] tri_cnt_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   max_ext;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    tri_sort3 #(
        .WIDTH (WIDTH)
    ) u_sort (
        .a   (a),
        .b   (b),
        .c   (c),
        .max (srt_max),
        .mid (srt_mid),
        .min (srt_min)
    );

    assign sum     = {1'b0, mid_q} + {1'b0, min_q};
    assign max_ext = {1'b0, max_q};

`ifdef TRIANGLE_RIGHT_EN
    logic [2*WIDTH-1:0] max_sq, mid_sq, min_sq;
    logic [2*WIDTH:0]   leg_sq_sum;

    assign max_sq     = {{WIDTH{1'b0}}, max_q} * {{WIDTH{1'b0}}, max_q};
    assign mid_sq     = {{WIDTH{1'b0}}, mid_q} * {{WIDTH{1'b0}}, mid_q};
    assign min_sq     = {{WIDTH{1'b0}}, min_q} * {{WIDTH{1'b0}}, min_q};
    assign leg_sq_sum = {1'b0, mid_sq} + {1'b0, min_sq};
`endif

    always_comb begin
        flags_d        = '0;
        flags_d.is_tri = !zero_q && (max_ext < sum);
        flags_d.degen  = !zero_q && (max_ext == sum);
        flags_d.equ    = flags_d.is_tri && eq_ab_q && eq_bc_q;
        flags_d.iso    = flags_d.is_tri && (eq_ab_q || eq_bc_q || eq_ac_q);
`ifdef TRIANGLE_RIGHT_EN
        flags_d.right  = flags_d.is_tri && ({1'b0, max_sq} == leg_sq_sum);
`else
        flags_d.right  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q       <= '0;
            mid_q       <= '0;
            min_q       <= '0;
            eq_ab_q     <= 1'b0;
            eq_bc_q     <= 1'b0;
            eq_ac_q     <= 1'b0;
            zero_q      <= 1'b0;
            v1_q        <= 1'b0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            max_q       <= srt_max;
            mid_q       <= srt_mid;
            min_q       <= srt_min;
            eq_ab_q     <= (a == b);
            eq_bc_q     <= (b == c);
            eq_ac_q     <= (a == c);
            zero_q      <= (srt_min == '0);
            v1_q        <= accept;
            flags_q     <= flags_d;
            out_valid_q <= v1_q;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_cnt_q <= '0;
        end else if (cnt_clr) begin
            tri_cnt_q <= '0;
        end else if (out_valid_q && out_ready && flags_q.is_tri && !(&tri_cnt_q)) begin
            tri_cnt_q <= tri_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign is_tri    = flags_q.is_tri;
    assign is_degen  = flags_q.degen;
    assign is_equ    = flags_q.equ;
    assign is_iso    = flags_q.iso;
    assign is_right  = flags_q.right;
    assign tri_cnt   = tri_cnt_q;

endmodule

// File: tb/tb_triangle_classifier.sv
// Self-checking bench for triangle_classifier: scoreboard of expected flags pushed on
// accept and compared on each output handshake, plus per-scenario inline checks.
module tb_triangle_classifier;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c;
    logic          out_valid;
    logic          out_ready;
    logic          is_tri, is_degen, is_equ, is_iso, is_right;
    logic          cnt_clr;
    logic [CW-1:0] tri_cnt;

    int checks = 0;
    int passed = 0;

    // {is_tri, degen, equ, iso, right}
    logic [4:0] sb[$];
    logic [4:0] mon_exp, mon_got;

    always #5 clk = ~clk;

    triangle_classifier #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .is_tri    (is_tri),
        .is_degen  (is_degen),
        .is_equ    (is_equ),
        .is_iso    (is_iso),
        .is_right  (is_right),
        .cnt_clr   (cnt_clr),
        .tri_cnt   (tri_cnt)
    );

    function automatic logic [4:0] model(input int unsigned x, input int unsigned y,
                                         input int unsigned z);
        int unsigned mx, rest;
        logic t, d, e, i, r;
        mx = x;
        if (y > mx) mx = y;
        if (z > mx) mx = z;
        rest = x + y + z - mx;
        t = (x != 0) && (y != 0) && (z != 0) && (mx < rest);
        d = (x != 0) && (y != 0) && (z != 0) && (mx == rest);
        e = t && (x == y) && (y == z);
        i = t && ((x == y) || (y == z) || (x == z));
`ifdef TRIANGLE_RIGHT_EN
        r = t && ((x*x + y*y == z*z) || (x*x + z*z == y*y) || (y*y + z*z == x*x));
`else
        r = 1'b0;
`endif
        return {t, d, e, i, r};
    endfunction

    // Output monitor: handshake scoreboard and the in_ready relation.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready))
                $display("FAIL in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            else
                passed++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL extra_result: got result %b, want none",
                             {is_tri, is_degen, is_equ, is_iso, is_right});
                end else begin
                    mon_exp = sb.pop_front();
                    mon_got = {is_tri, is_degen, is_equ, is_iso, is_right};
                    if (mon_got !== mon_exp)
                        $display("FAIL result_flags: got %b want %b", mon_got, mon_exp);
                    else
                        passed++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present a triple at posedge+1, hold until accepted; returns at posedge+1.
    task automatic send(input int unsigned x, input int unsigned y, input int unsigned z);
        bit done = 0;
        a = W'(x); b = W'(y); c = W'(z);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x, y, z));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: got in_ready 0 for 50 cycles, want 1");
        end
    endtask

    task automatic drain;
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        checks++;
        if (!done) $display("FAIL drain: got %0d pending results, want 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if (tri_cnt !== '0) $display("FAIL reset_tri_cnt: got %0d want 0", tri_cnt);
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        checks++;
        if (is_tri !== 1'b0) $display("FAIL reset_is_tri: got %b want 0", is_tri);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(3, 4, 5);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got out_valid %b want 0", out_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL latency_due: got out_valid %b want 1", out_valid);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (tri_cnt !== CW'(1)) $display("FAIL basic_cnt: got %0d want 1", tri_cnt);
        else passed++;
        drain();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(5, 5, 5);
        send(2, 3, 5);
        send(0, 4, 4);
        drain();
    endtask

    task automatic test_wide;
        out_ready = 1'b1;
        send(255, 255, 255);
        send(255, 128, 128);
        send(255, 1, 1);
        drain();
        checks++;
        if (tri_cnt !== CW'(4)) $display("FAIL wide_cnt: got %0d want 4", tri_cnt);
        else passed++;
    endtask

    task automatic test_random_stall;
        bit stop = 0;
        fork
            begin
                for (int n = 0; n < 10; n++)
                    send($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
                stop = 1;
            end
            begin
                for (int k = 0; k < 400 && !stop; k++) begin
                    out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        checks++;
        if (sb.size() != 0) $display("FAIL random_leftover: got %0d want 0", sb.size());
        else passed++;
    endtask

    task automatic test_counter;
        bit seen = 0;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (tri_cnt !== '0) $display("FAIL cnt_clear: got %0d want 0", tri_cnt);
        else passed++;
        for (int n = 0; n < 14; n++) send(3, 4, 5);
        drain();
        checks++;
        if (tri_cnt !== CW'(14)) $display("FAIL cnt_14: got %0d want 14", tri_cnt);
        else passed++;
        send(4, 4, 6);
        send(6, 7, 8);
        drain();
        checks++;
        if (tri_cnt !== CW'(15)) $display("FAIL cnt_saturate: got %0d want 15", tri_cnt);
        else passed++;
        send(3, 4, 5);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (!seen || tri_cnt !== '0)
            $display("FAIL cnt_clr_wins: got %0d (valid seen %b) want 0", tri_cnt, seen);
        else
            passed++;
        drain();
    endtask

    task automatic test_midstream_reset;
        out_ready = 1'b1;
        send(3, 4, 5);
        drain();
        checks++;
        if (tri_cnt !== CW'(1)) $display("FAIL pre_reset_cnt: got %0d want 1", tri_cnt);
        else passed++;
        out_ready = 1'b0;
        send(5, 5, 5);
        send(6, 8, 10);
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if (tri_cnt !== '0) $display("FAIL midreset_cnt: got %0d want 0", tri_cnt);
        else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) $display("FAIL stale_result: got out_valid %b want 0", out_valid);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0; b = '0; c = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wide();
        test_random_stall();
        test_counter();
        test_midstream_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
